// File: rtl/ioctl_pkg.sv
// Shared types and helpers for the ioctl upload path.
// Holds the reader FSM states, address widths and the byte-select helper.
package ioctl_pkg;

  localparam int IOCTL_AW = 25;
  localparam int MEM_AW   = 24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_e;

  function automatic logic [7:0] byte_sel(
    input logic [15:0] w,
    input logic        odd
  );
    return odd ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/ioctl_upload_reader.sv
// HPS upload reader: serves ioctl byte reads from the 16-bit memory port
// through a one-word cache, stalling the HPS while a fetch is outstanding.
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter logic [7:0]          INDEX   = 8'd4,
  parameter logic [IOCTL_AW-1:0] BASE    = 25'h0,
  parameter logic [IOCTL_AW-1:0] SIZE    = 25'h400,
  parameter logic [15:0]         TIMEOUT = 16'd4095
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic                mem_rd,
  output logic [MEM_AW-1:0]   mem_addr,
  input  logic [15:0]         mem_q,
  input  logic                mem_ack,
  input  logic                mem_inval,
  output logic                busy,
  output logic                err
);

  state_e              state_q, state_d;
  logic                active, active_q, active_d, rise;
  logic [MEM_AW-1:0]   tag_q, tag_d;
  logic [15:0]         data_q, data_d;
  logic                valid_q, valid_d;
  logic [MEM_AW-1:0]   maddr_q, maddr_d;
  logic                sel_q, sel_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [7:0]          din_q, din_d;
  logic                wait_q, wait_d;
  logic                mrd_q, mrd_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [IOCTL_AW-1:0] baddr;
  logic                oor, hit, tmo;

  assign active = ioctl_upload & (ioctl_index == INDEX);
  assign rise   = active & ~active_q;
  assign baddr  = BASE + ioctl_addr;
  assign oor    = ioctl_addr >= SIZE;
  assign tmo    = cnt_q >= TIMEOUT;
  // A same-cycle invalidate must win over a hit on the old tag
  assign hit    = valid_q & (tag_q == baddr[IOCTL_AW-1:1])
                & ~mem_inval & ~rise;

  always_comb begin
    state_d  = state_q;
    active_d = active;
    tag_d    = tag_q;
    data_d   = data_q;
    valid_d  = valid_q;
    maddr_d  = maddr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    din_d    = din_q;
    wait_d   = wait_q;
    mrd_d    = 1'b0;
    err_d    = err_q;
    if (rise) err_d = 1'b0;
    if (state_q != S_IDLE && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
    unique case (state_q)
      S_IDLE: begin
        if (active & ioctl_rd) begin
          if (oor) begin
            din_d = 8'hFF;
          end else if (hit) begin
            din_d = byte_sel(data_q, baddr[0]);
          end else begin
            maddr_d = baddr[IOCTL_AW-1:1];
            sel_d   = baddr[0];
            wait_d  = 1'b1;
            mrd_d   = 1'b1;
            cnt_d   = 16'd0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          tag_d   = maddr_q;
          data_d  = mem_q;
          valid_d = 1'b1;
          din_d   = byte_sel(mem_q, sel_q);
          wait_d  = 1'b0;
          state_d = S_IDLE;
        end else if (tmo) begin
          din_d   = 8'hFF;
          err_d   = 1'b1;
          valid_d = 1'b0;
          wait_d  = 1'b0;
          state_d = S_DRAIN;
        end else if (!active) begin
          wait_d  = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_ack || tmo) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (mem_inval || rise) valid_d = 1'b0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= S_IDLE;
      active_q <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      maddr_q  <= '0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      din_q    <= 8'h00;
      wait_q   <= 1'b0;
      mrd_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      maddr_q  <= maddr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      wait_q   <= wait_d;
      mrd_q    <= mrd_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_rd     = mrd_q;
  assign mem_addr   = maddr_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed bench for ioctl_upload_reader: cycle table plus corner sequences.
// u0 answers index 4 with BASE=0, u1 answers index 5 with BASE=1.
module tb_ioctl_upload_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        up;
  logic [7:0]  idx;
  logic        rd;
  logic [24:0] addr;
  logic [15:0] q;
  logic        ack;
  logic        inval;

  logic [7:0]  din0, din1;
  logic        wt0, wt1, mrd0, mrd1, busy0, busy1, err0, err1;
  logic [23:0] ma0, ma1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ioctl_upload_reader #(
    .INDEX(8'd4), .BASE(25'h0), .SIZE(25'h400), .TIMEOUT(16'd16)
  ) u0 (
    .clk_sys(clk), .reset(reset), .ioctl_upload(up),
    .ioctl_index(idx), .ioctl_rd(rd), .ioctl_addr(addr),
    .ioctl_din(din0), .ioctl_wait(wt0), .mem_rd(mrd0),
    .mem_addr(ma0), .mem_q(q), .mem_ack(ack),
    .mem_inval(inval), .busy(busy0), .err(err0)
  );

  ioctl_upload_reader #(
    .INDEX(8'd5), .BASE(25'h1), .SIZE(25'h400), .TIMEOUT(16'd16)
  ) u1 (
    .clk_sys(clk), .reset(reset), .ioctl_upload(up),
    .ioctl_index(idx), .ioctl_rd(rd), .ioctl_addr(addr),
    .ioctl_din(din1), .ioctl_wait(wt1), .mem_rd(mrd1),
    .mem_addr(ma1), .mem_q(q), .mem_ack(ack),
    .mem_inval(inval), .busy(busy1), .err(err1)
  );

  typedef struct {
    logic        up;
    logic [7:0]  idx;
    logic        rd;
    logic [24:0] addr;
    logic        ack;
    logic [15:0] q;
    logic        inval;
    logic [7:0]  e_din;
    logic        e_wait;
    logic        e_mrd;
    logic        e_busy;
    logic [23:0] e_ma;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic u, input logic [7:0] ix,
                       input logic r, input logic [24:0] a,
                       input logic k, input logic [15:0] d,
                       input logic iv);
    up = u; idx = ix; rd = r; addr = a;
    ack = k; q = d; inval = iv;
    @(posedge clk);
    #1;
    rd = 1'b0; ack = 1'b0; inval = 1'b0;
  endtask

  task automatic idle4();
    drive(1'b1, 8'd4, 1'b0, 25'h0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1,4,0,25'h000,0,16'h0000,0, 8'h00,0,0,0,24'h000};
    tbl[1]  = '{1,4,1,25'h000,0,16'h0000,0, 8'h00,1,1,1,24'h000};
    tbl[2]  = '{1,4,0,25'h000,0,16'h0000,0, 8'h00,1,0,1,24'h000};
    tbl[3]  = '{1,4,0,25'h000,0,16'h0000,0, 8'h00,1,0,1,24'h000};
    tbl[4]  = '{1,4,0,25'h000,0,16'h0000,0, 8'h00,1,0,1,24'h000};
    tbl[5]  = '{1,4,0,25'h000,1,16'hBEEF,0, 8'hEF,0,0,0,24'h000};
    tbl[6]  = '{1,4,1,25'h001,0,16'h0000,0, 8'hBE,0,0,0,24'h000};
    tbl[7]  = '{1,4,1,25'h400,0,16'h0000,0, 8'hFF,0,0,0,24'h000};
    tbl[8]  = '{1,4,1,25'h3FF,0,16'h0000,0, 8'hFF,1,1,1,24'h1FF};
    tbl[9]  = '{1,4,0,25'h000,1,16'h1234,0, 8'h12,0,0,0,24'h1FF};
    tbl[10] = '{1,7,1,25'h002,0,16'h0000,0, 8'h12,0,0,0,24'h1FF};
    tbl[11] = '{1,4,1,25'h001,0,16'h0000,0, 8'h12,1,1,1,24'h000};
    tbl[12] = '{1,4,0,25'h000,1,16'hAA55,1, 8'hAA,0,0,0,24'h000};
    tbl[13] = '{1,4,1,25'h000,0,16'h0000,0, 8'hAA,1,1,1,24'h000};
    tbl[14] = '{1,4,0,25'h000,1,16'hAA55,0, 8'h55,0,0,0,24'h000};
    tbl[15] = '{1,4,1,25'h000,0,16'h0000,1, 8'h55,1,1,1,24'h000};
    tbl[16] = '{1,4,0,25'h000,1,16'h0102,0, 8'h02,0,0,0,24'h000};
    tbl[17] = '{1,4,1,25'h001,0,16'h0000,0, 8'h01,0,0,0,24'h000};
    tbl[18] = '{1,4,0,25'h000,1,16'hFFFF,0, 8'h01,0,0,0,24'h000};

    reset = 1'b1; up = 1'b0; idx = 8'd0; rd = 1'b0;
    addr = '0; q = '0; ack = 1'b0; inval = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din",  32'(din0),  32'h00);
    chk("rst_wait", 32'(wt0),   32'h0);
    chk("rst_mrd",  32'(mrd0),  32'h0);
    chk("rst_ma",   32'(ma0),   32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_err",  32'(err0),  32'h0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].up, tbl[i].idx, tbl[i].rd, tbl[i].addr,
            tbl[i].ack, tbl[i].q, tbl[i].inval);
      chk($sformatf("row%0d_din", i),  32'(din0),  32'(tbl[i].e_din));
      chk($sformatf("row%0d_wait", i), 32'(wt0),   32'(tbl[i].e_wait));
      chk($sformatf("row%0d_mrd", i),  32'(mrd0),  32'(tbl[i].e_mrd));
      chk($sformatf("row%0d_busy", i), 32'(busy0), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d_ma", i),   32'(ma0),   32'(tbl[i].e_ma));
      chk($sformatf("row%0d_err", i),  32'(err0),  32'h0);
    end

    // timeout: no ack, wait falls 18 cycles after the strobe
    drive(1, 8'd4, 1, 25'h010, 0, 16'h0, 0);
    chk("to_mrd", 32'(mrd0), 32'h1);
    chk("to_ma",  32'(ma0),  32'h8);
    for (int j = 2; j <= 17; j++) begin
      idle4();
      chk($sformatf("to_wait_n%0d", j), 32'(wt0), 32'h1);
      chk($sformatf("to_mrd_n%0d", j),  32'(mrd0), 32'h0);
    end
    idle4();
    chk("to_wait18", 32'(wt0),   32'h0);
    chk("to_din18",  32'(din0),  32'hFF);
    chk("to_err18",  32'(err0),  32'h1);
    chk("to_busy18", 32'(busy0), 32'h1);
    idle4();
    chk("to_busy19", 32'(busy0), 32'h0);
    chk("to_err19",  32'(err0),  32'h1);
    drive(0, 8'd4, 0, 25'h0, 0, 16'h0, 0);
    idle4();
    chk("sess_err_clr", 32'(err0), 32'h0);

    // invalidate between two reads of one word
    drive(1, 8'd4, 1, 25'h020, 0, 16'h0, 0);
    chk("inv_mrd1", 32'(mrd0), 32'h1);
    chk("inv_ma1",  32'(ma0),  32'h10);
    drive(1, 8'd4, 0, 25'h0, 1, 16'hC3D4, 0);
    chk("inv_din1", 32'(din0), 32'hD4);
    drive(1, 8'd4, 0, 25'h0, 0, 16'h0, 1);
    drive(1, 8'd4, 1, 25'h021, 0, 16'h0, 0);
    chk("inv_mrd2", 32'(mrd0), 32'h1);
    drive(1, 8'd4, 0, 25'h0, 1, 16'hC3D4, 0);
    chk("inv_din2", 32'(din0), 32'hC3);

    // session dropped mid-fetch, late ack discarded
    drive(1, 8'd4, 1, 25'h030, 0, 16'h0, 0);
    chk("drop_mrd", 32'(mrd0), 32'h1);
    drive(0, 8'd4, 0, 25'h0, 0, 16'h0, 0);
    chk("drop_wait", 32'(wt0),   32'h0);
    chk("drop_busy", 32'(busy0), 32'h1);
    drive(0, 8'd4, 0, 25'h0, 0, 16'h0, 0);
    chk("drop_busy2", 32'(busy0), 32'h1);
    drive(0, 8'd4, 0, 25'h0, 1, 16'hDEAD, 0);
    chk("drop_busy3", 32'(busy0), 32'h0);
    chk("drop_din",   32'(din0),  32'hC3);
    drive(1, 8'd4, 1, 25'h030, 0, 16'h0, 0);
    chk("drop_refetch", 32'(mrd0), 32'h1);
    drive(1, 8'd4, 0, 25'h0, 1, 16'h7788, 0);
    chk("drop_din2", 32'(din0), 32'h88);

    // reset mid-fetch
    drive(1, 8'd4, 1, 25'h040, 0, 16'h0, 0);
    chk("rf_mrd", 32'(mrd0), 32'h1);
    reset = 1'b1;
    idle4();
    reset = 1'b0;
    chk("rf_din",  32'(din0),  32'h00);
    chk("rf_wait", 32'(wt0),   32'h0);
    chk("rf_mrd0", 32'(mrd0),  32'h0);
    chk("rf_ma",   32'(ma0),   32'h0);
    chk("rf_busy", 32'(busy0), 32'h0);
    chk("rf_err",  32'(err0),  32'h0);
    drive(1, 8'd4, 0, 25'h0, 1, 16'h1111, 0);
    chk("rf_late_din",  32'(din0),  32'h00);
    chk("rf_late_busy", 32'(busy0), 32'h0);
    drive(1, 8'd4, 1, 25'h040, 0, 16'h0, 0);
    chk("rf_miss", 32'(mrd0), 32'h1);
    drive(1, 8'd4, 0, 25'h0, 1, 16'h9922, 0);
    chk("rf_din2", 32'(din0), 32'h22);

    // BASE=1 instance
    drive(1, 8'd5, 1, 25'h000, 0, 16'h0, 0);
    chk("b1_mrd0", 32'(mrd1), 32'h1);
    chk("b1_ma0",  32'(ma1),  32'h0);
    chk("b1_u0q",  32'(mrd0), 32'h0);
    drive(1, 8'd5, 0, 25'h0, 1, 16'h3344, 0);
    chk("b1_din0", 32'(din1), 32'h33);
    drive(1, 8'd5, 1, 25'h001, 0, 16'h0, 0);
    chk("b1_mrd1", 32'(mrd1), 32'h1);
    chk("b1_ma1",  32'(ma1),  32'h1);
    drive(1, 8'd5, 0, 25'h0, 1, 16'h5566, 0);
    chk("b1_din1", 32'(din1), 32'h66);
    chk("b1_u0din", 32'(din0), 32'h22);
    drive(1, 8'd5, 1, 25'h400, 0, 16'h0, 0);
    chk("b1_oor_din", 32'(din1), 32'hFF);
    chk("b1_oor_mrd", 32'(mrd1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
